// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller.
// Covers FSM states, opcodes, ALU-op and mux select codes, and the opcode classifier.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_ADDIEX = 4'd8,
    S_ADDIWB = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_R    = 3'd1,
    CLS_LW   = 3'd2,
    CLS_SW   = 3'd3,
    CLS_BEQ  = 3'd4,
    CLS_ADDI = 3'd5,
    CLS_J    = 3'd6
  } op_class_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J    = 6'h02;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_REGB  = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic       pcwritecond;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       doshift;
  } ctrl_t;

  // Unknown opcodes map to CLS_NONE, which the FSM treats as illegal.
  function automatic op_class_t classify(input logic [5:0] op);
    case (op)
      OP_R:    classify = CLS_R;
      OP_LW:   classify = CLS_LW;
      OP_SW:   classify = CLS_SW;
      OP_BEQ:  classify = CLS_BEQ;
      OP_ADDI: classify = CLS_ADDI;
      OP_J:    classify = CLS_J;
      default: classify = CLS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// State to control-word decode for the multi-cycle controller.
// FETCH gates irwrite/pcwrite with the (already qualified) memory ready.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t i_state,
  input  logic   i_mem_ready,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_req = 1'b1;
        o_ctrl.memread = 1'b1;
        o_ctrl.alusrcb = ALUSRCB_FOUR;
        o_ctrl.irwrite = i_mem_ready;
        o_ctrl.pcwrite = i_mem_ready;
      end
      S_DECODE: o_ctrl.alusrcb = ALUSRCB_IMMSH;
      S_MEMADR, S_ADDIEX: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = ALUSRCB_IMM;
      end
      S_MEMRD: begin
        o_ctrl.mem_req = 1'b1;
        o_ctrl.memread = 1'b1;
        o_ctrl.iord    = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.mem_req  = 1'b1;
        o_ctrl.memwrite = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.memtoreg = 1'b1;
      end
      S_EXEC: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.aluop   = ALUOP_FUNCT;
        o_ctrl.doshift = 1'b1;
      end
      S_ALUWB: begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.regdst   = 1'b1;
      end
      S_ADDIWB: o_ctrl.regwrite = 1'b1;
      S_BRANCH: begin
        o_ctrl.alusrca     = 1'b1;
        o_ctrl.aluop       = ALUOP_SUB;
        o_ctrl.pcwritecond = 1'b1;
        o_ctrl.pcsrc       = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        o_ctrl.pcwrite = 1'b1;
        o_ctrl.pcsrc   = PCSRC_JUMP;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller: FSM, opcode-class latch and retired counter.
// Control outputs come from mc_ctrl_outdec; only FETCH write enables see mem_ready.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int CNT_W         = 32,
  parameter int ALUOP_W       = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               memread,
  output logic               memwrite,
  output logic               iord,
  output logic               irwrite,
  output logic               pcwrite,
  output logic               pcwritecond,
  output logic [1:0]         pcsrc,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [ALUOP_W-1:0] aluop,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               doshift,
  output logic               illegal_op,
  output logic [CNT_W-1:0]   retired,
  output logic [3:0]         state_dbg
);

  state_t           r_state;
  op_class_t        r_cls;
  logic [CNT_W-1:0] r_retired;

  logic      w_ready;
  op_class_t w_cls;
  ctrl_t     w_ctrl;

  // Without the handshake every access completes in a single cycle.
  assign w_ready = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign w_cls   = classify(opcode);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_cls     <= CLS_NONE;
      r_retired <= '0;
    end else begin
      case (r_state)
        S_FETCH: if (w_ready) r_state <= S_DECODE;
        S_DECODE: begin
          r_cls <= w_cls;
          case (w_cls)
            CLS_R:         r_state <= S_EXEC;
            CLS_LW, CLS_SW: r_state <= S_MEMADR;
            CLS_BEQ:       r_state <= S_BRANCH;
            CLS_ADDI:      r_state <= S_ADDIEX;
            CLS_J:         r_state <= S_JUMP;
            default:       r_state <= S_FETCH;
          endcase
        end
        S_MEMADR: r_state <= (r_cls == CLS_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (w_ready) r_state <= S_MEMWB;
        S_MEMWR: begin
          if (w_ready) begin
            r_state   <= S_FETCH;
            r_retired <= r_retired + CNT_W'(1);
          end
        end
        S_EXEC:   r_state <= S_ALUWB;
        S_ADDIEX: r_state <= S_ADDIWB;
        S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
          r_state   <= S_FETCH;
          r_retired <= r_retired + CNT_W'(1);
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  mc_ctrl_outdec u_outdec (
    .i_state     (r_state),
    .i_mem_ready (w_ready),
    .o_ctrl      (w_ctrl)
  );

  assign mem_req     = w_ctrl.mem_req;
  assign memread     = w_ctrl.memread;
  assign memwrite    = w_ctrl.memwrite;
  assign iord        = w_ctrl.iord;
  assign irwrite     = w_ctrl.irwrite;
  assign pcwrite     = w_ctrl.pcwrite;
  assign pcwritecond = w_ctrl.pcwritecond;
  assign pcsrc       = w_ctrl.pcsrc;
  assign alusrca     = w_ctrl.alusrca;
  assign alusrcb     = w_ctrl.alusrcb;
  assign aluop       = ALUOP_W'(w_ctrl.aluop);
  assign regdst      = w_ctrl.regdst;
  assign memtoreg    = w_ctrl.memtoreg;
  assign regwrite    = w_ctrl.regwrite;
  assign doshift     = w_ctrl.doshift;
  assign illegal_op  = (r_state == S_DECODE) && (w_cls == CLS_NONE);
  assign retired     = r_retired;
  assign state_dbg   = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed table-driven bench for multicycle_control plus a counter-wrap run
// on a second instance with CNT_W=4 and the memory handshake disabled.
module tb_multicycle_control;
  import mc_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Control word order: mem_req memread memwrite iord irwrite pcwrite pcwritecond
  // pcsrc[1:0] alusrca alusrcb[1:0] aluop[1:0] regdst memtoreg regwrite doshift
  localparam logic [17:0] C_FETCH_R = {7'b1100110, 2'b00, 1'b0, 2'b01, 2'b00, 4'b0000};
  localparam logic [17:0] C_FETCH_W = {7'b1100000, 2'b00, 1'b0, 2'b01, 2'b00, 4'b0000};
  localparam logic [17:0] C_DECODE  = {7'b0000000, 2'b00, 1'b0, 2'b11, 2'b00, 4'b0000};
  localparam logic [17:0] C_MEMADR  = {7'b0000000, 2'b00, 1'b1, 2'b10, 2'b00, 4'b0000};
  localparam logic [17:0] C_MEMRD   = {7'b1101000, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000};
  localparam logic [17:0] C_MEMWR   = {7'b1011000, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000};
  localparam logic [17:0] C_MEMWB   = {7'b0000000, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0110};
  localparam logic [17:0] C_EXEC    = {7'b0000000, 2'b00, 1'b1, 2'b00, 2'b10, 4'b0001};
  localparam logic [17:0] C_ALUWB   = {7'b0000000, 2'b00, 1'b0, 2'b00, 2'b00, 4'b1010};
  localparam logic [17:0] C_ADDIWB  = {7'b0000000, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0010};
  localparam logic [17:0] C_BRANCH  = {7'b0000001, 2'b01, 1'b1, 2'b00, 2'b01, 4'b0000};
  localparam logic [17:0] C_JUMP    = {7'b0000010, 2'b10, 1'b0, 2'b00, 2'b00, 4'b0000};

  // Main instance: handshake on, 32-bit counter
  logic        rst_n, mem_ready;
  logic [5:0]  opcode;
  logic        mem_req, memread, memwrite, iord, irwrite, pcwrite, pcwritecond;
  logic [1:0]  pcsrc, alusrcb, aluop;
  logic        alusrca, regdst, memtoreg, regwrite, doshift, illegal_op;
  logic [31:0] retired;
  logic [3:0]  state_dbg;
  logic [17:0] cw;

  multicycle_control #(.MEM_HANDSHAKE(1), .CNT_W(32), .ALUOP_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .memread(memread), .memwrite(memwrite), .iord(iord),
    .irwrite(irwrite), .pcwrite(pcwrite), .pcwritecond(pcwritecond), .pcsrc(pcsrc),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .doshift(doshift),
    .illegal_op(illegal_op), .retired(retired), .state_dbg(state_dbg)
  );
  assign cw = {mem_req, memread, memwrite, iord, irwrite, pcwrite, pcwritecond, pcsrc,
               alusrca, alusrcb, aluop, regdst, memtoreg, regwrite, doshift};

  // Second instance: no handshake, 4-bit counter
  logic        rst2_n, mem_ready2;
  logic [5:0]  opcode2;
  logic        mem_req2, memread2, memwrite2, iord2, irwrite2, pcwrite2, pcwritecond2;
  logic [1:0]  pcsrc2, alusrcb2, aluop2;
  logic        alusrca2, regdst2, memtoreg2, regwrite2, doshift2, illegal_op2;
  logic [3:0]  retired2;
  logic [3:0]  state_dbg2;
  logic [17:0] cw2;

  multicycle_control #(.MEM_HANDSHAKE(0), .CNT_W(4), .ALUOP_W(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .opcode(opcode2), .mem_ready(mem_ready2),
    .mem_req(mem_req2), .memread(memread2), .memwrite(memwrite2), .iord(iord2),
    .irwrite(irwrite2), .pcwrite(pcwrite2), .pcwritecond(pcwritecond2), .pcsrc(pcsrc2),
    .alusrca(alusrca2), .alusrcb(alusrcb2), .aluop(aluop2), .regdst(regdst2),
    .memtoreg(memtoreg2), .regwrite(regwrite2), .doshift(doshift2),
    .illegal_op(illegal_op2), .retired(retired2), .state_dbg(state_dbg2)
  );
  assign cw2 = {mem_req2, memread2, memwrite2, iord2, irwrite2, pcwrite2, pcwritecond2, pcsrc2,
                alusrca2, alusrcb2, aluop2, regdst2, memtoreg2, regwrite2, doshift2};

  typedef struct {
    logic        rst_n;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [17:0] cw;
    logic        ill;
    logic [31:0] ret;
  } vec_t;

  localparam int NV = 35;
  vec_t tbl [NV];
  int   tests  = 0;
  int   failed = 0;

  function automatic vec_t v(logic r, logic [5:0] op, logic rdy, logic [3:0] st,
                             logic [17:0] c, logic ill, logic [31:0] ret);
    vec_t t;
    t.rst_n = r; t.op = op; t.rdy = rdy; t.st = st; t.cw = c; t.ill = ill; t.ret = ret;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  logic [3:0] addi_st [4];
  logic [17:0] addi_cw [4];

  initial begin
    // Each row: inputs driven for this cycle, outputs expected before the next edge
    // LW, zero wait; MEMADR sees a decoy SW opcode
    tbl[0]  = v(1, 6'h23, 1, S_FETCH,  C_FETCH_R, 0, 0);
    tbl[1]  = v(1, 6'h23, 1, S_DECODE, C_DECODE,  0, 0);
    tbl[2]  = v(1, 6'h2B, 1, S_MEMADR, C_MEMADR,  0, 0);
    tbl[3]  = v(1, 6'h2B, 1, S_MEMRD,  C_MEMRD,   0, 0);
    tbl[4]  = v(1, 6'h00, 1, S_MEMWB,  C_MEMWB,   0, 0);
    // SW with three wait cycles in MEMWR
    tbl[5]  = v(1, 6'h2B, 1, S_FETCH,  C_FETCH_R, 0, 1);
    tbl[6]  = v(1, 6'h2B, 1, S_DECODE, C_DECODE,  0, 1);
    tbl[7]  = v(1, 6'h23, 1, S_MEMADR, C_MEMADR,  0, 1);
    tbl[8]  = v(1, 6'h23, 0, S_MEMWR,  C_MEMWR,   0, 1);
    tbl[9]  = v(1, 6'h23, 0, S_MEMWR,  C_MEMWR,   0, 1);
    tbl[10] = v(1, 6'h23, 0, S_MEMWR,  C_MEMWR,   0, 1);
    tbl[11] = v(1, 6'h23, 1, S_MEMWR,  C_MEMWR,   0, 1);
    // BEQ then J
    tbl[12] = v(1, 6'h04, 1, S_FETCH,  C_FETCH_R, 0, 2);
    tbl[13] = v(1, 6'h04, 1, S_DECODE, C_DECODE,  0, 2);
    tbl[14] = v(1, 6'h04, 1, S_BRANCH, C_BRANCH,  0, 2);
    tbl[15] = v(1, 6'h02, 1, S_FETCH,  C_FETCH_R, 0, 3);
    tbl[16] = v(1, 6'h02, 1, S_DECODE, C_DECODE,  0, 3);
    tbl[17] = v(1, 6'h02, 1, S_JUMP,   C_JUMP,    0, 3);
    // Illegal opcode
    tbl[18] = v(1, 6'h3F, 1, S_FETCH,  C_FETCH_R, 0, 4);
    tbl[19] = v(1, 6'h3F, 1, S_DECODE, C_DECODE,  1, 4);
    // R-type with one fetch wait
    tbl[20] = v(1, 6'h00, 0, S_FETCH,  C_FETCH_W, 0, 4);
    tbl[21] = v(1, 6'h00, 1, S_FETCH,  C_FETCH_R, 0, 4);
    tbl[22] = v(1, 6'h00, 1, S_DECODE, C_DECODE,  0, 4);
    tbl[23] = v(1, 6'h00, 1, S_EXEC,   C_EXEC,    0, 4);
    tbl[24] = v(1, 6'h00, 1, S_ALUWB,  C_ALUWB,   0, 4);
    // ADDI
    tbl[25] = v(1, 6'h08, 1, S_FETCH,  C_FETCH_R, 0, 5);
    tbl[26] = v(1, 6'h08, 1, S_DECODE, C_DECODE,  0, 5);
    tbl[27] = v(1, 6'h08, 1, S_ADDIEX, C_MEMADR,  0, 5);
    tbl[28] = v(1, 6'h08, 1, S_ADDIWB, C_ADDIWB,  0, 5);
    // LW abandoned by reset while waiting in MEMRD
    tbl[29] = v(1, 6'h23, 1, S_FETCH,  C_FETCH_R, 0, 6);
    tbl[30] = v(1, 6'h23, 1, S_DECODE, C_DECODE,  0, 6);
    tbl[31] = v(1, 6'h23, 1, S_MEMADR, C_MEMADR,  0, 6);
    tbl[32] = v(1, 6'h23, 0, S_MEMRD,  C_MEMRD,   0, 6);
    tbl[33] = v(0, 6'h23, 0, S_MEMRD,  C_MEMRD,   0, 6);
    tbl[34] = v(1, 6'h23, 1, S_FETCH,  C_FETCH_R, 0, 0);

    addi_st[0] = S_FETCH;  addi_cw[0] = C_FETCH_R;
    addi_st[1] = S_DECODE; addi_cw[1] = C_DECODE;
    addi_st[2] = S_ADDIEX; addi_cw[2] = C_MEMADR;
    addi_st[3] = S_ADDIWB; addi_cw[3] = C_ADDIWB;

    rst_n = 1'b0; opcode = 6'h00; mem_ready = 1'b1;
    rst2_n = 1'b0; opcode2 = 6'h08; mem_ready2 = 1'b0;

    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst_n     = tbl[i].rst_n;
      opcode    = tbl[i].op;
      mem_ready = tbl[i].rdy;
      #1;
      chk("state",   i, 32'(state_dbg),  32'(tbl[i].st));
      chk("ctrl",    i, 32'(cw),         32'(tbl[i].cw));
      chk("illegal", i, 32'(illegal_op), 32'(tbl[i].ill));
      chk("retired", i, retired,         tbl[i].ret);
    end

    // 16 ADDIs on the no-handshake instance with mem_ready held low
    for (int k = 0; k < 16; k++) begin
      for (int s = 0; s < 4; s++) begin
        @(negedge clk);
        rst2_n = 1'b1;
        #1;
        chk("nohs_state",   k * 4 + s, 32'(state_dbg2), 32'(addi_st[s]));
        chk("nohs_ctrl",    k * 4 + s, 32'(cw2),        32'(addi_cw[s]));
        chk("nohs_retired", k * 4 + s, 32'(retired2),   32'(k));
      end
    end
    @(negedge clk);
    #1;
    chk("wrap_state",   64, 32'(state_dbg2), 32'(S_FETCH));
    chk("wrap_retired", 64, 32'(retired2),   32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
